// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   DATA_W_DEF / ADDR_W_DEF : default data and register-index widths
//   NUM_REGS                : scoreboard depth for the default index width
//   req_id_t                : requester identity, used as the last-grant pointer
package rf_writeback_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file
// write port.
//   a_valid/a_ready/a_reg/a_data : requester A handshake and payload
//   b_valid/b_ready/b_reg/b_data : requester B handshake and payload
//   rf_reg_write/rf_write_reg/rf_write_data : registered register-file write port
// Modports:
//   master : requester / register-file side (drives requests, sees grants and writes)
//   slave  : arbiter side
interface rf_writeback_arbiter_if
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;

    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;

    logic              rf_reg_write;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;

    modport master (
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        input  a_ready, b_ready,
        input  rf_reg_write, rf_write_reg, rf_write_data
    );

    modport slave (
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        output a_ready, b_ready,
        output rf_reg_write, rf_write_reg, rf_write_data
    );
endinterface

// File: rtl/rf_writeback_arbiter_scoreboard.sv
// rf_scoreboard: busy bit per destination register with an outstanding write.
//   clk, reset          : clock, asynchronous active-high reset
//   issue_valid/issue_reg : set busy[issue_reg] on the edge (index 0 ignored)
//   wr_en/wr_reg        : register-file write in this cycle, clears busy[wr_reg]
//   chk_reg1/chk_reg2   : source indices to look up
//   hazard1/hazard2     : combinational busy lookup for each source
//   busy_vec            : full scoreboard contents
module rf_scoreboard
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_reg,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_reg,
    input  logic [ADDR_W-1:0]    chk_reg1,
    input  logic [ADDR_W-1:0]    chk_reg2,
    output logic                 hazard1,
    output logic                 hazard2,
    output logic [2**ADDR_W-1:0] busy_vec
);
    localparam int N = 2 ** ADDR_W;

    logic [N-1:0] busy_q;
    logic [N-1:0] busy_d;

    // Set has priority over clear: an instruction issuing to a register that
    // is being written back this very cycle owns a fresh outstanding write.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < N; i++) begin
            if (wr_en && wr_reg == ADDR_W'(i)) begin
                busy_d[i] = 1'b0;
            end
            if (issue_valid && issue_reg == ADDR_W'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Bit 0 is held at zero, so a lookup of register 0 never reports a hazard.
    assign hazard1  = busy_q[chk_reg1];
    assign hazard2  = busy_q[chk_reg2];
    assign busy_vec = busy_q;
endmodule

// File: rtl/rf_writeback_arbiter.sv
// Round-robin arbiter sharing the register file write port between requester A
// (ALU/immediate) and requester B (load/multi-cycle), with a registered output
// stage and a busy-bit scoreboard for read-after-write hazard detection.
//   clk, reset      : clock, asynchronous active-high reset
//   wb              : requester handshakes and register-file write port (slave side)
//   issue_valid/issue_reg : destination of an issuing instruction, marked busy
//   chk_reg1/chk_reg2     : source indices to check
//   hazard1/hazard2       : corresponding source is busy
//   busy_vec              : scoreboard contents
module rf_writeback_arbiter
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    rf_writeback_arbiter_if.slave wb,
    input  logic                  issue_valid,
    input  logic [ADDR_W-1:0]     issue_reg,
    input  logic [ADDR_W-1:0]     chk_reg1,
    input  logic [ADDR_W-1:0]     chk_reg2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic [2**ADDR_W-1:0]  busy_vec
);
    req_id_t           last_q;
    req_id_t           last_d;
    logic              xfer;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_reg_q;
    logic [DATA_W-1:0] rf_data_q;

    // Grants depend only on the valids and the pointer; on contention the
    // requester that did not win last time gets the port.
    always_comb begin
        wb.a_ready = 1'b0;
        wb.b_ready = 1'b0;
        last_d     = last_q;
        xfer       = 1'b0;
        sel_reg    = wb.a_reg;
        sel_data   = wb.a_data;
        if (wb.a_valid && (!wb.b_valid || last_q == REQ_B)) begin
            wb.a_ready = 1'b1;
            last_d     = REQ_A;
            xfer       = 1'b1;
        end else if (wb.b_valid) begin
            wb.b_ready = 1'b1;
            last_d     = REQ_B;
            xfer       = 1'b1;
            sel_reg    = wb.b_reg;
            sel_data   = wb.b_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

    // A transfer to register 0 still loads the stage but never raises the
    // write enable, since register 0 is hard-wired.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_q   <= 1'b0;
            rf_reg_q  <= '0;
            rf_data_q <= '0;
        end else begin
            rf_we_q <= xfer && (sel_reg != '0);
            if (xfer) begin
                rf_reg_q  <= sel_reg;
                rf_data_q <= sel_data;
            end
        end
    end

    assign wb.rf_reg_write  = rf_we_q;
    assign wb.rf_write_reg  = rf_reg_q;
    assign wb.rf_write_data = rf_data_q;

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .wr_en       (rf_we_q),
        .wr_reg      (rf_reg_q),
        .chk_reg1    (chk_reg1),
        .chk_reg2    (chk_reg2),
        .hazard1     (hazard1),
        .hazard2     (hazard2),
        .busy_vec    (busy_vec)
    );
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
module tb_rf_writeback_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_reg;
    logic [ADDR_W-1:0] chk_reg1;
    logic [ADDR_W-1:0] chk_reg2;
    logic              hazard1;
    logic              hazard2;
    logic [31:0]       busy_vec;

    int tests_run = 0;
    int tests_failed = 0;

    rf_writeback_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

    rf_writeback_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb          (wb),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .chk_reg1    (chk_reg1),
        .chk_reg2    (chk_reg2),
        .hazard1     (hazard1),
        .hazard2     (hazard2),
        .busy_vec    (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_reg   = '0;
        chk_reg1    = '0;
        chk_reg2    = '0;
        wb.a_valid  = 1'b0;
        wb.a_reg    = '0;
        wb.a_data   = '0;
        wb.b_valid  = 1'b0;
        wb.b_reg    = '0;
        wb.b_data   = '0;
        tick();
        tick();

        check("rst_we",    64'(wb.rf_reg_write), 64'd0);
        check("rst_reg",   64'(wb.rf_write_reg), 64'd0);
        check("rst_data",  64'(wb.rf_write_data), 64'd0);
        check("rst_busy",  64'(busy_vec), 64'd0);
        check("rst_haz1",  64'(hazard1), 64'd0);
        reset = 1'b0;

        // A alone: reg 3, data 0x11
        wb.a_valid = 1'b1; wb.a_reg = 5'd3; wb.a_data = 32'h11;
        #1;
        check("a_only_ready_a", 64'(wb.a_ready), 64'd1);
        check("a_only_ready_b", 64'(wb.b_ready), 64'd0);
        tick();
        wb.a_valid = 1'b0;
        check("a_only_we",   64'(wb.rf_reg_write), 64'd1);
        check("a_only_reg",  64'(wb.rf_write_reg), 64'd3);
        check("a_only_data", 64'(wb.rf_write_data), 64'h11);

        // B alone moves the pointer to B so the next contest starts with A
        wb.b_valid = 1'b1; wb.b_reg = 5'd4; wb.b_data = 32'h44;
        #1;
        check("b_only_ready_b", 64'(wb.b_ready), 64'd1);
        tick();
        wb.b_valid = 1'b0;
        check("b_only_reg",  64'(wb.rf_write_reg), 64'd4);
        check("b_only_data", 64'(wb.rf_write_data), 64'h44);

        // Contention for 4 cycles: A, B, A, B
        wb.a_valid = 1'b1; wb.a_reg = 5'd1; wb.a_data = 32'hA0;
        wb.b_valid = 1'b1; wb.b_reg = 5'd2; wb.b_data = 32'hB0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_ready_a", 64'(wb.a_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
            check("rr_ready_b", 64'(wb.b_ready), (k % 2 == 0) ? 64'd0 : 64'd1);
            tick();
            check("rr_we",   64'(wb.rf_reg_write), 64'd1);
            check("rr_reg",  64'(wb.rf_write_reg), (k % 2 == 0) ? 64'd1 : 64'd2);
            check("rr_data", 64'(wb.rf_write_data),
                  (k % 2 == 0) ? 64'(32'hA0 + k / 2) : 64'(32'hB0 + k / 2));
            if (k % 2 == 0) wb.a_data = 32'hA1;
            else            wb.b_data = 32'hB1;
        end
        wb.a_valid = 1'b0;
        wb.b_valid = 1'b0;
        tick();
        check("idle_we",   64'(wb.rf_reg_write), 64'd0);
        check("idle_reg",  64'(wb.rf_write_reg), 64'd2);
        check("idle_data", 64'(wb.rf_write_data), 64'hB1);

        // Issue reg 5, then B writes it back
        issue_valid = 1'b1; issue_reg = 5'd5; chk_reg1 = 5'd5;
        #1;
        check("haz_before_issue", 64'(hazard1), 64'd0);
        tick();
        issue_valid = 1'b0;
        check("haz_after_issue", 64'(hazard1), 64'd1);
        check("busy_r5", 64'(busy_vec), 64'h20);
        wb.b_valid = 1'b1; wb.b_reg = 5'd5; wb.b_data = 32'h55;
        #1;
        check("r5_ready_b", 64'(wb.b_ready), 64'd1);
        tick();
        wb.b_valid = 1'b0;
        check("r5_we", 64'(wb.rf_reg_write), 64'd1);
        check("r5_haz_during_write", 64'(hazard1), 64'd1);
        tick();
        check("r5_haz_cleared", 64'(hazard1), 64'd0);
        check("r5_busy_cleared", 64'(busy_vec), 64'd0);

        // Set and clear of reg 7 in the same cycle: set wins
        issue_valid = 1'b1; issue_reg = 5'd7;
        wb.a_valid = 1'b1; wb.a_reg = 5'd7; wb.a_data = 32'h77;
        tick();
        wb.a_valid = 1'b0;
        check("r7_we", 64'(wb.rf_reg_write), 64'd1);
        check("r7_reg", 64'(wb.rf_write_reg), 64'd7);
        check("r7_busy_set", 64'(busy_vec), 64'h80);
        tick();
        issue_valid = 1'b0;
        check("r7_set_wins", 64'(busy_vec), 64'h80);
        chk_reg2 = 5'd7;
        #1;
        check("r7_haz2", 64'(hazard2), 64'd1);

        // B alone (pointer -> B), then A writes reg 0 (pointer -> A)
        wb.b_valid = 1'b1; wb.b_reg = 5'd6; wb.b_data = 32'h66;
        tick();
        wb.b_valid = 1'b0;
        wb.a_valid = 1'b1; wb.a_reg = 5'd0; wb.a_data = 32'h99;
        #1;
        check("r0_ready_a", 64'(wb.a_ready), 64'd1);
        tick();
        wb.a_valid = 1'b0;
        check("r0_we", 64'(wb.rf_reg_write), 64'd0);
        wb.a_valid = 1'b1; wb.a_reg = 5'd1; wb.a_data = 32'h1234;
        wb.b_valid = 1'b1; wb.b_reg = 5'd2; wb.b_data = 32'h5678;
        #1;
        check("r0_adv_ready_a", 64'(wb.a_ready), 64'd0);
        check("r0_adv_ready_b", 64'(wb.b_ready), 64'd1);
        tick();
        wb.b_valid = 1'b0;
        check("r0_adv_reg", 64'(wb.rf_write_reg), 64'd2);
        tick();
        wb.a_valid = 1'b0;
        check("post_r0_a_reg", 64'(wb.rf_write_reg), 64'd1);

        // Issue reg 0 leaves the scoreboard alone
        issue_valid = 1'b1; issue_reg = 5'd0; chk_reg2 = 5'd0;
        tick();
        issue_valid = 1'b0;
        check("issue_r0_busy", 64'(busy_vec), 64'h80);
        check("chk_r0_haz2", 64'(hazard2), 64'd0);

        // Build busy = 0xF0, then reset mid-operation
        issue_valid = 1'b1;
        issue_reg = 5'd4; tick();
        issue_reg = 5'd5; tick();
        issue_reg = 5'd6; tick();
        issue_valid = 1'b0;
        check("busy_f0", 64'(busy_vec), 64'hF0);
        wb.a_valid = 1'b1; wb.a_reg = 5'd1; wb.a_data = 32'hAA;
        wb.b_valid = 1'b1; wb.b_reg = 5'd2; wb.b_data = 32'hBB;
        tick();
        check("pre_rst_we", 64'(wb.rf_reg_write), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_we",   64'(wb.rf_reg_write), 64'd0);
        check("async_rst_reg",  64'(wb.rf_write_reg), 64'd0);
        check("async_rst_busy", 64'(busy_vec), 64'd0);
        check("async_rst_haz1", 64'(hazard1), 64'd0);
        check("async_rst_ready_a", 64'(wb.a_ready), 64'd1);
        check("async_rst_ready_b", 64'(wb.b_ready), 64'd0);
        tick();
        reset = 1'b0;
        wb.a_valid = 1'b0;
        wb.b_valid = 1'b0;
        tick();
        check("post_rst_we", 64'(wb.rf_reg_write), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
